// File: rtl/eic_ahb_ctrl_if.sv
// eic_ahb_ctrl_if
// AHB-Lite bus bundle between a bus master/interconnect and eic_ahb_ctrl.
//   HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HREADY : master -> slave
//   HRDATA, HREADYOUT, HRESP                           : slave  -> master
// HREADY is the system-wide ready, normally produced by the interconnect.
interface eic_ahb_ctrl_if;
   logic        HSEL;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport master (
      output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/eic_ahb_ctrl.sv
// eic_ahb_ctrl
// AHB-Lite slave holding the configuration of the external interrupt
// controller (eic): channel mask, sense modes, forced set/clear strobes, and
// read-back of pending flags and the current interrupt number.
// Ports:
//   CLK, RESETn    : clock, asynchronous active-low reset
//   bus            : AHB-Lite slave bundle (eic_ahb_ctrl_if.slave)
//   request        : channel flags from eic
//   EIC_Interrupt  : current interrupt number from eic
//   mask           : channel enables to eic (EIMSK gated by EICR.EN)
//   senceMask      : 2-bit sense mode per sense channel
//   requestWR      : one-cycle forced flag write strobe
//   requestIn      : forced flag value (1 = set, 0 = clear)
module eic_ahb_ctrl #(
   parameter int EIC_DIRECT_CHANNELS = 31,
   parameter int EIC_SENSE_CHANNELS  = 32,
   parameter int EIC_TOTAL_CHANNELS  = EIC_DIRECT_CHANNELS + EIC_SENSE_CHANNELS
) (
   input  logic                              CLK,
   input  logic                              RESETn,
   eic_ahb_ctrl_if.slave                     bus,
   input  logic [EIC_TOTAL_CHANNELS-1:0]     request,
   input  logic [7:0]                        EIC_Interrupt,
   output logic [EIC_TOTAL_CHANNELS-1:0]     mask,
   output logic [2*EIC_SENSE_CHANNELS-1:0]   senceMask,
   output logic [EIC_TOTAL_CHANNELS-1:0]     requestWR,
   output logic [EIC_TOTAL_CHANNELS-1:0]     requestIn
);

   localparam int TOTAL = EIC_TOTAL_CHANNELS;
   localparam int SMW   = 2 * EIC_SENSE_CHANNELS;

   // Word index = HADDR[5:2]; _H halves sit at even indices 2..10.
   localparam logic [3:0] REG_EICR     = 4'd0;
   localparam logic [3:0] REG_EIMSK_L  = 4'd1;
   localparam logic [3:0] REG_EIMSK_H  = 4'd2;
   localparam logic [3:0] REG_EIFR_L   = 4'd3;
   localparam logic [3:0] REG_EIFR_H   = 4'd4;
   localparam logic [3:0] REG_EIFRS_L  = 4'd5;
   localparam logic [3:0] REG_EIFRS_H  = 4'd6;
   localparam logic [3:0] REG_EIFRC_L  = 4'd7;
   localparam logic [3:0] REG_EIFRC_H  = 4'd8;
   localparam logic [3:0] REG_EISMSK_L = 4'd9;
   localparam logic [3:0] REG_EISMSK_H = 4'd10;
   localparam logic [3:0] REG_EIIRQ    = 4'd11;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t           state_q, state_d;
   logic [3:0]       addr_q;
   logic             write_q;
   logic             en_q, en_d;
   logic [TOTAL-1:0] eimsk_q, eimsk_d;
   logic [SMW-1:0]   eismsk_q, eismsk_d;
   logic [TOTAL-1:0] req_wr_q, req_wr_d;
   logic [TOTAL-1:0] req_in_q, req_in_d;

   logic             accept, addr_err;
   logic             wr_en, rd_en;
   logic             hi_half;
   logic [63:0]      lane_mask, wdata_lane;
   logic [63:0]      eimsk_pad, eismsk_pad, req_pad;
   logic [63:0]      eimsk_new, eismsk_new;
   logic [63:0]      rd64;
   logic             unused_bits;

   // ---------------------------------------------------------------------
   // Address phase
   // ---------------------------------------------------------------------
   assign accept   = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
   assign addr_err = (bus.HADDR[5:2] > REG_EIIRQ) | (bus.HSIZE != 3'b010);

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         addr_q  <= 4'd0;
         write_q <= 1'b0;
      end else if (accept) begin
         addr_q  <= bus.HADDR[5:2];
         write_q <= bus.HWRITE;
      end
   end

   // ---------------------------------------------------------------------
   // Transfer FSM: state register / next state / outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_ERR1: state_d = ST_ERR2;
         default: if (accept) state_d = addr_err ? ST_ERR1 : ST_DATA;
      endcase
   end

   always_comb begin
      bus.HREADYOUT = 1'b1;
      bus.HRESP     = 1'b0;
      wr_en         = 1'b0;
      rd_en         = 1'b0;
      case (state_q)
         ST_DATA: begin
            wr_en = write_q;
            rd_en = ~write_q;
         end
         ST_ERR1: begin
            bus.HREADYOUT = 1'b0;
            bus.HRESP     = 1'b1;
         end
         ST_ERR2: bus.HRESP = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // 64-bit views of the logical registers; bits beyond the channel count
   // are tied to zero so they read 0 and can never be written.
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < 64; gi++) begin : g_pad
      if (gi < TOTAL) begin : g_ch
         assign eimsk_pad[gi] = eimsk_q[gi];
         assign req_pad[gi]   = request[gi];
      end else begin : g_no_ch
         assign eimsk_pad[gi] = 1'b0;
         assign req_pad[gi]   = 1'b0;
      end
      if (gi < SMW) begin : g_sm
         assign eismsk_pad[gi] = eismsk_q[gi];
      end else begin : g_no_sm
         assign eismsk_pad[gi] = 1'b0;
      end
   end

   assign hi_half    = ~addr_q[0] & (addr_q != REG_EICR);
   assign lane_mask  = hi_half ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF};
   assign wdata_lane = {bus.HWDATA, bus.HWDATA} & lane_mask;
   assign eimsk_new  = (eimsk_pad  & ~lane_mask) | wdata_lane;
   assign eismsk_new = (eismsk_pad & ~lane_mask) | wdata_lane;

   // ---------------------------------------------------------------------
   // Register write path (HWDATA sampled at the end of the data phase)
   // ---------------------------------------------------------------------
   always_comb begin
      en_d     = en_q;
      eimsk_d  = eimsk_q;
      eismsk_d = eismsk_q;
      req_wr_d = '0;
      req_in_d = '0;
      if (wr_en) begin
         case (addr_q)
            REG_EICR:                   en_d     = bus.HWDATA[0];
            REG_EIMSK_L, REG_EIMSK_H:   eimsk_d  = eimsk_new[TOTAL-1:0];
            REG_EISMSK_L, REG_EISMSK_H: eismsk_d = eismsk_new[SMW-1:0];
            REG_EIFRS_L, REG_EIFRS_H: begin
               req_wr_d = wdata_lane[TOTAL-1:0];
               req_in_d = wdata_lane[TOTAL-1:0];
            end
            REG_EIFRC_L, REG_EIFRC_H:   req_wr_d = wdata_lane[TOTAL-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         en_q     <= 1'b0;
         eimsk_q  <= '0;
         eismsk_q <= '0;
         req_wr_q <= '0;
         req_in_q <= '0;
      end else begin
         en_q     <= en_d;
         eimsk_q  <= eimsk_d;
         eismsk_q <= eismsk_d;
         req_wr_q <= req_wr_d;
         req_in_q <= req_in_d;
      end
   end

   // ---------------------------------------------------------------------
   // Read path: combinational from the latched address, zero otherwise
   // ---------------------------------------------------------------------
   always_comb begin
      rd64 = '0;
      case (addr_q)
         REG_EICR:                   rd64 = {63'b0, en_q};
         REG_EIMSK_L, REG_EIMSK_H:   rd64 = eimsk_pad;
         REG_EIFR_L, REG_EIFR_H:     rd64 = req_pad;
         REG_EISMSK_L, REG_EISMSK_H: rd64 = eismsk_pad;
         REG_EIIRQ:                  rd64 = {56'b0, EIC_Interrupt};
         default: ;
      endcase
   end

   assign bus.HRDATA = rd_en ? (hi_half ? rd64[63:32] : rd64[31:0]) : 32'h0;

   // ---------------------------------------------------------------------
   // Outputs to eic
   // ---------------------------------------------------------------------
   assign mask      = en_q ? eimsk_q : '0;
   assign senceMask = eismsk_q;
   assign requestWR = req_wr_q;
   assign requestIn = req_in_q;

   // Address bits and lane bits that the decode never looks at.
   assign unused_bits = ^{bus.HADDR[31:6], bus.HADDR[1:0], bus.HTRANS[0],
                          wdata_lane, eimsk_new, eismsk_new};

endmodule

// File: tb/tb_eic_ahb_ctrl.sv
module tb_eic_ahb_ctrl;
   localparam int TOTAL = 63;

   logic             CLK = 1'b0;
   logic             RESETn = 1'b1;
   logic [TOTAL-1:0] request;
   logic [7:0]       EIC_Interrupt;
   logic [TOTAL-1:0] mask;
   logic [63:0]      senceMask;
   logic [TOTAL-1:0] requestWR;
   logic [TOTAL-1:0] requestIn;
   logic [31:0]      rdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   eic_ahb_ctrl_if bus ();
   assign bus.HREADY = bus.HREADYOUT;

   eic_ahb_ctrl dut (
      .CLK           (CLK),
      .RESETn        (RESETn),
      .bus           (bus),
      .request       (request),
      .EIC_Interrupt (EIC_Interrupt),
      .mask          (mask),
      .senceMask     (senceMask),
      .requestWR     (requestWR),
      .requestIn     (requestIn)
   );

   // Minimal stand-in for eic flags: only forced writes move them.
   logic [TOTAL-1:0] flags_q;
   always @(posedge CLK or negedge RESETn) begin
      if (!RESETn) flags_q <= '0;
      else         flags_q <= (flags_q & ~requestWR) | (requestWR & requestIn);
   end
   assign request = flags_q;

   // Lowest pending channel wins; interrupt number = channel + 1.
   always_comb begin
      EIC_Interrupt = 8'd0;
      for (int i = TOTAL - 1; i >= 0; i--)
         if (flags_q[i]) EIC_Interrupt = 8'(i + 1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HADDR  = a;
      bus.HWRITE = wr;
      bus.HSIZE  = sz;
   endtask

   task automatic idle_bus();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'b0;
      bus.HSIZE  = 3'b010;
   endtask

   // Returns one tick after the data-phase edge (strobes visible then).
   task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
      addr_phase(a, 1'b1, 3'b010);
      tick();
      idle_bus();
      bus.HWDATA = d;
      $display("write addr=%h data=%h hresp=%b", a, d, bus.HRESP);
      tick();
   endtask

   task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
      addr_phase(a, 1'b0, 3'b010);
      tick();
      d = bus.HRDATA;
      $display("read  addr=%h data=%h hresp=%b", a, d, bus.HRESP);
      chk("read_hresp", 64'(bus.HRESP), 64'h0);
      idle_bus();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle_bus();
      bus.HADDR  = 32'h0;
      bus.HWDATA = 32'h0;

      // Asynchronous reset: values must appear without a clock edge.
      #2 RESETn = 1'b0;
      #1;
      chk("rst_hreadyout", 64'(bus.HREADYOUT), 64'h1);
      chk("rst_hresp",     64'(bus.HRESP),     64'h0);
      chk("rst_hrdata",    64'(bus.HRDATA),    64'h0);
      chk("rst_mask",      64'(mask),          64'h0);
      chk("rst_sencemask", senceMask,          64'h0);
      chk("rst_requestwr", 64'(requestWR),     64'h0);
      chk("rst_requestin", 64'(requestIn),     64'h0);
      tick();
      tick();
      RESETn = 1'b1;
      tick();

      // Every register reads 0 after reset (no flags pending, EIIRQ 0).
      for (int r = 0; r < 12; r++) begin
         ahb_read(32'(r * 4), rdata);
         chk($sformatf("rst_read_%0d", r), 64'(rdata), 64'h0);
      end

      // Mask stays off until EN is set.
      ahb_write(32'h04, 32'h0000_0005);
      chk("mask_en0", 64'(mask), 64'h0);
      ahb_read(32'h04, rdata);
      chk("eimsk_l_rd", 64'(rdata), 64'h5);
      ahb_write(32'h00, 32'h0000_0001);
      chk("mask_en1", 64'(mask), 64'h5);
      ahb_read(32'h00, rdata);
      chk("eicr_rd", 64'(rdata), 64'h1);

      // Forced set of channel 40 via EIFRS_H bit 8.
      ahb_write(32'h18, 32'h0000_0100);
      chk("set_wr", 64'(requestWR), 64'h0000_0100_0000_0000);
      chk("set_in", 64'(requestIn), 64'h0000_0100_0000_0000);
      tick();
      chk("set_wr_1cyc", 64'(requestWR), 64'h0);
      ahb_read(32'h10, rdata);
      chk("eifr_h_set", 64'(rdata), 64'h100);
      ahb_read(32'h2C, rdata);
      chk("eiirq_41", 64'(rdata), 64'd41);

      // Forced clear of channel 40 via EIFRC_H.
      ahb_write(32'h20, 32'h0000_0100);
      chk("clr_wr", 64'(requestWR), 64'h0000_0100_0000_0000);
      chk("clr_in", 64'(requestIn), 64'h0);
      tick();
      ahb_read(32'h10, rdata);
      chk("eifr_h_clr", 64'(rdata), 64'h0);
      ahb_read(32'h2C, rdata);
      chk("eiirq_0", 64'(rdata), 64'h0);

      // Sense modes: all rising-edge on the low 16 sense channels.
      ahb_write(32'h24, 32'hFFFF_FFFF);
      chk("sencemask_l", senceMask, 64'h0000_0000_FFFF_FFFF);
      ahb_read(32'h28, rdata);
      chk("eismsk_h_rd", 64'(rdata), 64'h0);

      // Back-to-back write/read of EIMSK_H; bit 63 does not exist.
      addr_phase(32'h08, 1'b1, 3'b010);
      tick();
      bus.HWDATA = 32'hFFFF_FFFF;
      addr_phase(32'h08, 1'b0, 3'b010);
      tick();
      $display("b2b   addr=%h data=%h hresp=%b", 32'h08, bus.HRDATA, bus.HRESP);
      chk("b2b_rd", 64'(bus.HRDATA), 64'h7FFF_FFFF);
      chk("b2b_mask", 64'(mask), 64'h7FFF_FFFF_0000_0005);
      idle_bus();
      tick();

      // Consecutive set then clear: one strobe per cycle, no merging.
      addr_phase(32'h14, 1'b1, 3'b010);
      tick();
      bus.HWDATA = 32'h1;
      addr_phase(32'h1C, 1'b1, 3'b010);
      tick();
      chk("seq_set_wr", 64'(requestWR), 64'h1);
      chk("seq_set_in", 64'(requestIn), 64'h1);
      idle_bus();
      bus.HWDATA = 32'h1;
      tick();
      chk("seq_clr_wr", 64'(requestWR), 64'h1);
      chk("seq_clr_in", 64'(requestIn), 64'h0);
      tick();
      chk("seq_idle_wr", 64'(requestWR), 64'h0);
      $display("seq   set/clear strobes on EIFRS_L/EIFRC_L bit 0");

      // Write to read-only EIFR is ignored with OKAY.
      ahb_write(32'h0C, 32'hFFFF_FFFF);
      chk("eifr_wr_hresp", 64'(bus.HRESP), 64'h0);
      chk("eifr_wr_nostrobe", 64'(requestWR), 64'h0);

      // Unmapped read: two-cycle ERROR.
      addr_phase(32'h30, 1'b0, 3'b010);
      tick();
      chk("err1_hreadyout", 64'(bus.HREADYOUT), 64'h0);
      chk("err1_hresp",     64'(bus.HRESP),     64'h1);
      idle_bus();
      tick();
      chk("err2_hreadyout", 64'(bus.HREADYOUT), 64'h1);
      chk("err2_hresp",     64'(bus.HRESP),     64'h1);
      chk("err2_hrdata",    64'(bus.HRDATA),    64'h0);
      tick();
      chk("err_done_hresp", 64'(bus.HRESP), 64'h0);
      $display("error read addr=30 done");

      // Byte-size write to EIMSK_L: ERROR, register untouched.
      addr_phase(32'h04, 1'b1, 3'b000);
      tick();
      chk("sz_err1_hreadyout", 64'(bus.HREADYOUT), 64'h0);
      chk("sz_err1_hresp",     64'(bus.HRESP),     64'h1);
      idle_bus();
      bus.HWDATA = 32'hFFFF_FFFF;
      tick();
      chk("sz_err2_hreadyout", 64'(bus.HREADYOUT), 64'h1);
      chk("sz_err2_hresp",     64'(bus.HRESP),     64'h1);
      tick();
      $display("error write addr=04 size=0 done");
      ahb_read(32'h04, rdata);
      chk("sz_err_eimsk", 64'(rdata), 64'h5);

      // Reset during the data phase of an EIFRS write.
      addr_phase(32'h14, 1'b1, 3'b010);
      tick();
      idle_bus();
      bus.HWDATA = 32'hFFFF_FFFF;
      #2 RESETn = 1'b0;
      #1;
      chk("mid_rst_mask",      64'(mask),          64'h0);
      chk("mid_rst_sencemask", senceMask,          64'h0);
      chk("mid_rst_hreadyout", 64'(bus.HREADYOUT), 64'h1);
      chk("mid_rst_hresp",     64'(bus.HRESP),     64'h0);
      tick();
      chk("mid_rst_nostrobe",  64'(requestWR),     64'h0);
      chk("mid_rst_requestin", 64'(requestIn),     64'h0);
      $display("reset during EIFRS write data phase");
      RESETn = 1'b1;
      tick();
      ahb_read(32'h00, rdata);
      chk("post_rst_eicr", 64'(rdata), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
